// File: rtl/capture_pkg.sv
// Shared types and constants for the capture controller.
package capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrefill,
    StArmed,
    StPost,
    StDone,
    StHoldoff
  } cap_state_t;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

endpackage

// File: rtl/cap_counter.sv
// Loadable saturating up-counter with a terminal-count compare against 'term'.
module cap_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             inc,
  input  logic [Width-1:0] term,
  output logic             tc
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load wins over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/capture_controller.sv
// Sequences one sample-buffer acquisition around a trigger: prefill, armed ring
// writing, post-trigger fill, then done/holdoff with optional automatic re-arm.
module capture_controller
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic [CNT_W-1:0]  auto_timeout,
  input  logic              trig,
  input  logic              ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              forced,
  output logic              done,
  output logic              busy
);

  cap_state_t state_q, state_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              forced_q, forced_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Settings latched on an accepted arm and reused by every holdoff re-arm.
  logic [ADDR_W-1:0] p_q, p_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  holdoff_q, holdoff_d;

  logic              ph_load, ph_inc, ph_tc;
  logic [ADDR_W-1:0] ph_term;
  logic              tm_load, tm_inc, tm_tc;
  logic [CNT_W-1:0]  tm_term;

  logic              trig_ev;
  logic              restart;
  logic [ADDR_W-1:0] restart_p;

  // Phase counter: last write of PREFILL is count P-1, of POST is (DEPTH-1-P)-1.
  // DEPTH-1-P is simply ~P at ADDR_W bits.
  assign ph_term = (state_q == StPost) ? (~p_q - 1'b1) : (p_q - 1'b1);

  // Shared counter: holdoff length in HOLDOFF, auto-timeout compare in ARMED.
  assign tm_term = (state_q == StHoldoff) ? (holdoff_q - 1'b1) : auto_timeout;

  cap_counter #(
    .Width(ADDR_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ph_load),
    .load_val('0),
    .inc     (ph_inc),
    .term    (ph_term),
    .tc      (ph_tc)
  );

  cap_counter #(
    .Width(CNT_W)
  ) u_time_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tm_load),
    .load_val('0),
    .inc     (tm_inc),
    .term    (tm_term),
    .tc      (tm_tc)
  );

  // Next-state, address and latch logic; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    forced_d     = forced_q;
    p_d          = p_q;
    mode_d       = mode_q;
    holdoff_d    = holdoff_q;
    ph_load      = 1'b0;
    ph_inc       = 1'b0;
    tm_load      = 1'b0;
    tm_inc       = 1'b0;
    trig_ev      = 1'b0;
    restart      = 1'b0;
    restart_p    = p_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            p_d       = pretrig;
            mode_d    = mode;
            holdoff_d = holdoff;
            restart   = 1'b1;
            restart_p = pretrig;
          end
        end
        StPrefill: begin
          wr_addr_d = wr_addr_q + 1'b1;
          ph_inc    = 1'b1;
          if (ph_tc) begin
            state_d = StArmed;
            tm_load = 1'b1;
          end
        end
        StArmed: begin
          wr_addr_d = wr_addr_q + 1'b1;
          tm_inc    = 1'b1;
          trig_ev   = trig | ((mode_q == MODE_AUTO) && (auto_timeout != '0) && tm_tc);
          if (trig_ev) begin
            trig_addr_d  = wr_addr_q;
            start_addr_d = wr_addr_q - p_q;
            forced_d     = ~trig;
            ph_load      = 1'b1;
            // No post-trigger samples remain when P = DEPTH-1.
            state_d      = (p_q == '1) ? StDone : StPost;
          end
        end
        StPost: begin
          wr_addr_d = wr_addr_q + 1'b1;
          ph_inc    = 1'b1;
          if (ph_tc) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (ack) begin
            if (mode_q == MODE_SINGLE) begin
              state_d = StIdle;
            end else if (holdoff_q == '0) begin
              restart = 1'b1;
            end else begin
              state_d = StHoldoff;
              tm_load = 1'b1;
            end
          end
        end
        StHoldoff: begin
          tm_inc = 1'b1;
          if (tm_tc) begin
            restart = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Common entry into a new record (arm or re-arm).
    if (restart) begin
      state_d   = (restart_p == '0) ? StArmed : StPrefill;
      wr_addr_d = '0;
      forced_d  = 1'b0;
      ph_load   = 1'b1;
      tm_load   = 1'b1;
    end
  end

  // Registered status outputs follow the next state.
  always_comb begin
    wr_en_d = (state_d == StPrefill) || (state_d == StArmed) || (state_d == StPost);
    done_d  = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      forced_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      p_q          <= '0;
      mode_q       <= MODE_NORMAL;
      holdoff_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      forced_q     <= forced_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      p_q          <= p_d;
      mode_q       <= mode_d;
      holdoff_q    <= holdoff_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign forced     = forced_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller at ADDR_W=4 (DEPTH=16).
module tb_capture_controller;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 24;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, abort, trig, ack;
  logic [1:0]    mode;
  logic [AW-1:0] pretrig;
  logic [CW-1:0] holdoff, auto_timeout;
  logic          wr_en, forced, done, busy;
  logic [AW-1:0] wr_addr, trig_addr, start_addr;

  capture_controller #(
    .ADDR_W(AW),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .abort       (abort),
    .mode        (mode),
    .pretrig     (pretrig),
    .holdoff     (holdoff),
    .auto_timeout(auto_timeout),
    .trig        (trig),
    .ack         (ack),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .trig_addr   (trig_addr),
    .start_addr  (start_addr),
    .forced      (forced),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] mode;
    int         pretrig;
    int         holdoff;
    int         tmo;
    int         trig_idx;   // write index of the trigger sample
    bit         is_auto;    // trigger comes from the timeout, trig pin stays low
    int         pf_trig;    // write index of a stray trig pulse in PREFILL, -1 none
    int         exp_trig;
    int         exp_start;
    bit         exp_forced;
  } rec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic arm_dut(input logic [1:0] m, input int p, input int h, input int t);
    mode         = m;
    pretrig      = AW'(p);
    holdoff      = CW'(h);
    auto_timeout = CW'(t);
    arm          = 1'b1;
    @(negedge clk);
    arm          = 1'b0;
  endtask

  // Arm, drive the trigger, score every write address, and stop in DONE.
  task automatic run_rec(input rec_t r);
    int n;
    int widx;
    int cyc;
    n = r.trig_idx + 1 + (DEPTH - 1 - r.pretrig);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(i % DEPTH);
    arm_dut(r.mode, r.pretrig, r.holdoff, r.tmo);
    widx = 0;
    for (cyc = 0; cyc < 400 && done !== 1'b1; cyc++) begin
      trig = 1'b0;
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 32'(wr_addr), 32'hFFFF);
        end else begin
          chk("wr_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
        end
        if ((!r.is_auto && widx == r.trig_idx) || widx == r.pf_trig) trig = 1'b1;
        widx++;
      end
      @(negedge clk);
    end
    trig = 1'b0;
    chk("done_reached", 32'(done), 1);
    chk("writes_left", 32'(exp_q.size()), 0);
    chk("wr_en_in_done", 32'(wr_en), 0);
    chk("trig_addr", 32'(trig_addr), 32'(r.exp_trig));
    chk("start_addr", 32'(start_addr), 32'(r.exp_start));
    chk("forced", 32'(forced), 32'(r.exp_forced));
    // A trig pulse in DONE must not disturb the record.
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("done_trig_done", 32'(done), 1);
    chk("done_trig_addr", 32'(trig_addr), 32'(r.exp_trig));
  endtask

  rec_t vec[7];
  rec_t r;

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; ack = 1'b0;
    mode = 2'd0; pretrig = '0; holdoff = '0; auto_timeout = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    //          mode  P   H  tmo  k   auto pf  trig start forced
    vec[0] = '{2'd0,  4,  0,  0,  9,  1'b0,  1,  9,  5, 1'b0};
    vec[1] = '{2'd1,  0,  0, 20, 20,  1'b1, -1,  4,  4, 1'b1};
    vec[2] = '{2'd0, 15,  0,  0, 15,  1'b0, -1, 15,  0, 1'b0};
    vec[3] = '{2'd0,  0,  0,  0,  0,  1'b0, -1,  0,  0, 1'b0};
    vec[4] = '{2'd3,  2,  0,  5, 12,  1'b0, -1, 12, 10, 1'b0};
    vec[5] = '{2'd1,  3,  0, 30,  6,  1'b0, -1,  6,  3, 1'b0};
    vec[6] = '{2'd1,  5,  0,  0, 25,  1'b0, -1,  9,  4, 1'b0};

    foreach (vec[i]) begin
      run_rec(vec[i]);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_keep_trig", 32'(trig_addr), 32'(vec[i].exp_trig));
    end

    // Single mode: ack returns to IDLE with no re-arm.
    r = '{2'd2, 2, 0, 0, 5, 1'b0, -1, 5, 3, 1'b0};
    run_rec(r);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("single_done", 32'(done), 0);
    chk("single_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("single_no_rearm", 32'(wr_en), 0);

    // Normal mode with holdoff=3: three idle cycles, then PREFILL from address 0.
    r = '{2'd0, 4, 3, 0, 9, 1'b0, -1, 9, 5, 1'b0};
    run_rec(r);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("hold_done_clr", 32'(done), 0);
    chk("hold_wr_en1", 32'(wr_en), 0);
    @(negedge clk);
    chk("hold_wr_en2", 32'(wr_en), 0);
    @(negedge clk);
    chk("hold_wr_en3", 32'(wr_en), 0);
    @(negedge clk);
    chk("rearm_wr_en", 32'(wr_en), 1);
    chk("rearm_addr0", 32'(wr_addr), 0);
    @(negedge clk);
    chk("rearm_addr1", 32'(wr_addr), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Abort during POST: IDLE next cycle and no done afterwards.
    arm_dut(2'd0, 4, 0, 0);
    repeat (9) @(negedge clk);
    chk("post_pre_addr", 32'(wr_addr), 9);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("post_abort_wr_en", 32'(wr_en), 0);
    chk("post_abort_busy", 32'(busy), 0);
    chk("post_abort_trig", 32'(trig_addr), 9);
    chk("post_abort_start", 32'(start_addr), 5);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (done === 1'b1) seen++;
        @(negedge clk);
      end
      chk("post_abort_no_done", 32'(seen), 0);
    end

    // trig and abort in the same ARMED cycle: abort wins.
    arm_dut(2'd0, 0, 0, 0);
    repeat (3) @(negedge clk);
    trig = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    abort = 1'b0;
    chk("trig_abort_busy", 32'(busy), 0);
    chk("trig_abort_addr", 32'(trig_addr), 9);

    // arm and abort together in IDLE: stays IDLE.
    mode = 2'd0; pretrig = '0;
    arm = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_busy", 32'(busy), 0);
    chk("arm_abort_wr_en", 32'(wr_en), 0);

    // trig in IDLE is ignored.
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("idle_trig_busy", 32'(busy), 0);
    chk("idle_trig_addr", 32'(trig_addr), 9);

    // Asynchronous reset mid-PREFILL, between clock edges.
    arm_dut(2'd0, 8, 0, 0);
    repeat (3) @(negedge clk);
    chk("pf_wr_en", 32'(wr_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 0);
    chk("arst_wr_addr", 32'(wr_addr), 0);
    chk("arst_trig_addr", 32'(trig_addr), 0);
    chk("arst_start_addr", 32'(start_addr), 0);
    chk("arst_forced", 32'(forced), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
